// File: rtl/rotor_stage.sv
// Single rotor stage: programmable wiring with a forward and an inverse table,
// position-offset letter translation, stepping, and a notch carry to the next rotor.
module rotor_stage #(
  parameter int N     = 26,
  parameter int W     = 5,
  parameter int NOTCH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         pos_load,
  input  logic [W-1:0] pos_val,
  input  logic         step_in,
  input  logic         in_valid,
  input  logic [W-1:0] in_letter,
  input  logic         dir,
  output logic         out_valid,
  output logic [W-1:0] out_letter,
  output logic         err,
  output logic         carry_out,
  output logic [W-1:0] pos
);

  localparam logic [W:0]   N_EXT   = (W+1)'(N);
  localparam logic [W-1:0] NOTCH_W = W'(NOTCH);

  logic [W-1:0] fwd_reg [N];
  logic [W-1:0] inv_reg [N];
  logic [W-1:0] pos_reg, pos_next;
  logic [W-1:0] out_letter_reg, out_letter_next;
  logic         out_valid_reg, err_reg, carry_reg;
  logic         out_valid_next, err_next, carry_next;

  logic         wr_ok, letter_ok;
  logic [W:0]   c_sum, d_diff;
  logic [W-1:0] c_idx, m_val;

  assign wr_ok     = cfg_we && ({1'b0, cfg_addr} < N_EXT) && ({1'b0, cfg_data} < N_EXT);
  assign letter_ok = (in_letter != '0) && ({1'b0, in_letter} <= N_EXT);

  // Contact = (L-1+P) mod N; map through table; result = ((m-P) mod N)+1.
  always_comb begin
    c_sum = {1'b0, in_letter} - (W+1)'(1) + {1'b0, pos_reg};
    if (c_sum >= N_EXT) c_sum = c_sum - N_EXT;
    c_idx = letter_ok ? c_sum[W-1:0] : '0;
    m_val = dir ? inv_reg[c_idx] : fwd_reg[c_idx];
    d_diff = {1'b0, m_val} - {1'b0, pos_reg};
    if (d_diff[W]) d_diff = d_diff + N_EXT;
  end

  always_comb begin
    out_valid_next  = in_valid;
    err_next        = in_valid && !letter_ok;
    out_letter_next = out_letter_reg;
    if (in_valid) out_letter_next = letter_ok ? (d_diff[W-1:0] + W'(1)) : '0;
  end

  // Load beats step; an out-of-range load is dropped and also blocks the step.
  always_comb begin
    pos_next   = pos_reg;
    carry_next = step_in && !pos_load && (pos_reg == NOTCH_W);
    if (pos_load) begin
      if ({1'b0, pos_val} < N_EXT) pos_next = pos_val;
    end else if (step_in) begin
      pos_next = ({1'b0, pos_reg} == N_EXT - (W+1)'(1)) ? '0 : pos_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg        <= '0;
      out_letter_reg <= '0;
      out_valid_reg  <= 1'b0;
      err_reg        <= 1'b0;
      carry_reg      <= 1'b0;
    end else begin
      pos_reg        <= pos_next;
      out_letter_reg <= out_letter_next;
      out_valid_reg  <= out_valid_next;
      err_reg        <= err_next;
      carry_reg      <= carry_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        fwd_reg[i] <= W'(i);
        inv_reg[i] <= W'(i);
      end
    end else if (wr_ok) begin
      fwd_reg[cfg_addr] <= cfg_data;
      inv_reg[cfg_data] <= cfg_addr;
    end
  end

  assign pos        = pos_reg;
  assign out_letter = out_letter_reg;
  assign out_valid  = out_valid_reg;
  assign err        = err_reg;
  assign carry_out  = carry_reg;

endmodule

// File: doc/rotor_stage.md
ROTOR_STAGE -- requirements
Module: rotor_stage

Interface
REQ-001 Parameter N, default 26, alphabet size (letters encoded 1..N, 0 = invalid).
REQ-002 Parameter W, default 5, letter/position width; SHALL satisfy 2^W > N.
REQ-003 Parameter NOTCH, default 16, 0-based position at which a step produces carry_out.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_we  input  1  wiring-table write strobe.
REQ-007 cfg_addr  input  W  0-based contact index to write.
REQ-008 cfg_data  input  W  0-based mapped contact value.
REQ-009 pos_load  input  1  load rotor position from pos_val.
REQ-010 pos_val  input  W  0-based position to load.
REQ-011 step_in  input  1  one-cycle step request (keypress or upstream carry).
REQ-012 in_valid  input  1  in_letter is valid this cycle.
REQ-013 in_letter  input  W  letter to translate, 1..N.
REQ-014 dir  input  1  0 = forward path (fwd table), 1 = reverse path (inv table).
REQ-015 out_valid  output  1  out_letter valid, one-cycle pulse.
REQ-016 out_letter  output  W  translated letter 1..N, 0 on error.
REQ-017 err  output  1  in_letter out of range for the accepted letter.
REQ-018 carry_out  output  1  one-cycle pulse to step the next rotor.
REQ-019 pos  output  W  current rotor position 0..N-1.

Function
REQ-020 Block SHALL hold two N-entry tables of W bits: fwd and inv, both flop-based.
REQ-021 Write (cfg_we=1, cfg_addr<N, cfg_data<N): fwd[cfg_addr]<=cfg_data and inv[cfg_data]<=cfg_addr in the same edge; writes with either field >=N SHALL be ignored entirely.
REQ-022 Non-permutation writes leave stale inv entries; no repair SHALL be performed.
REQ-023 Translation, in_letter L in 1..N, position P: c = (L-1+P) mod N; m = T[c] (T = fwd if dir=0, inv if dir=1); out_letter = ((m-P) mod N)+1.
REQ-024 Modular arithmetic SHALL use W+1-bit intermediates with a single conditional add/subtract of N; no divider.
REQ-025 Latency: result registered; out_valid/out_letter/err appear the edge after in_valid=1; no backpressure, one letter per cycle sustained.
REQ-026 in_letter=0 or >N with in_valid=1: out_valid=1, out_letter=0, err=1 next cycle.
REQ-027 in_valid=0: out_valid=0 and err=0 next cycle; out_letter holds last value.
REQ-028 Translation SHALL use pos and table contents before the current edge (read-before-write for simultaneous cfg_we, step_in, pos_load).
REQ-029 Position update priority: pos_load (pos<=pos_val if pos_val<N, else unchanged) over step_in (pos<=pos+1, wrapping N-1 -> 0) over hold.
REQ-030 carry_out SHALL pulse 1 for exactly one cycle, the edge after a step_in accepted while pos==NOTCH; pos_load suppresses carry in that cycle.
REQ-031 step_in held high multiple cycles SHALL step once per cycle, with carry per REQ-030 each time.

Reset
REQ-032 rst_n=0 SHALL immediately force pos=0, out_valid=0, out_letter=0, err=0, carry_out=0, fwd[i]=i, inv[i]=i for all i.
REQ-033 Assertion mid-operation SHALL discard any in-flight result; first out_valid after release requires a new in_valid.
REQ-034 Inputs SHALL be ignored while rst_n=0.

Verification
REQ-035 After reset, pos=0, in_letter=1 dir=0 -> out_letter=1, out_valid=1 one cycle later, err=0.
REQ-036 Write fwd[0]=4; pos=0 in_letter=1 dir=0 -> 5; in_letter=5 dir=1 -> 1.
REQ-037 Write fwd[3]=9; pos_load 3; in_letter=1 dir=0 -> out_letter=7.
REQ-038 pos_load 25, step_in one cycle -> pos=0, carry_out=0; pos_load 16, step_in -> pos=17, carry_out=1 for one cycle only.
REQ-039 in_letter=0 then 27 with in_valid=1 -> out_letter=0, err=1 each; next valid letter clears err.
REQ-040 in_valid with simultaneous step_in at pos=2 -> translation uses pos=2, pos becomes 3; rst_n pulse mid-stream -> out_valid=0 and pos=0 immediately.
